mem_store_capture: RTL and testbench

Passive snooper on the CPU–memory bus that records every processor store (CS and WE both high) into a first-in first-out queue of address/data pairs, and presents them to a consumer through a valid/ready read port. It sits beside `Memory`, in parallel with the bus, and never drives the bus. It replaces ad-hoc `@(posedge WE)` bus sampling in benches and serves as a hardware store-trace buffer on the board.

---
 rtl/mem_store_capture.sv | 108 ++++++++++
 tb/tb_mem_store_capture.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_store_capture.sv
// Passive store-trace buffer: snoops CPU stores (CS & WE) inside an address window
// into a FWFT queue read out over a valid/ready port, with sticky drop accounting.
module mem_store_capture #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int WIN_LO = 0,
  parameter int WIN_HI = 127
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CS,
  input  logic                      WE,
  input  logic [ADDR_W-1:0]         Address,
  input  logic [DATA_W-1:0]         Mem_Bus,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [ADDR_W-1:0]         rd_addr,
  output logic [DATA_W-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [7:0]                drop_cnt,
  input  logic                      clr_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] WIN_LO_A = WIN_LO[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] WIN_HI_A = WIN_HI[ADDR_W-1:0];

  logic [PW:0]         wr_ptr_q, wr_ptr_d;
  logic [PW:0]         rd_ptr_q, rd_ptr_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;
  logic [ADDR_W-1:0]   addr_mem_q [DEPTH];
  logic [DATA_W-1:0]   data_mem_q [DEPTH];

  logic lo_ok, hi_ok;
  logic cap, empty, full, push, pop, drop;

  // Window bounds that cover the whole address range are elided so no
  // constant comparison is built.
  if (WIN_LO <= 0) begin : g_lo_all
    assign lo_ok = 1'b1;
  end else begin : g_lo_cmp
    assign lo_ok = (Address >= WIN_LO_A);
  end

  if (WIN_HI >= (1 << ADDR_W) - 1) begin : g_hi_all
    assign hi_ok = 1'b1;
  end else begin : g_hi_cmp
    assign hi_ok = (Address <= WIN_HI_A);
  end

  assign cap   = CS & WE & lo_ok & hi_ok;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
  assign pop   = rd_valid & rd_ready;
  // A pop on a full queue frees the slot the same-cycle push lands in.
  assign push  = cap & (~full | pop);
  assign drop  = cap & full & ~pop;

  assign rd_valid = ~empty;
  assign rd_addr  = addr_mem_q[rd_ptr_q[PW-1:0]];
  assign rd_data  = data_mem_q[rd_ptr_q[PW-1:0]];
  assign count    = wr_ptr_q - rd_ptr_q;
  assign overflow = ovf_q;
  assign drop_cnt = drop_cnt_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    if (clr_ovf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = 8'd0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is not reset; a write during reset is harmless because the
  // pointers are cleared in the same edge.
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_mem_q[wr_ptr_q[PW-1:0]] <= Address;
      data_mem_q[wr_ptr_q[PW-1:0]] <= Mem_Bus;
    end
  end

endmodule

// File: tb/tb_mem_store_capture.sv
// Directed bench for mem_store_capture: queue scoreboard per instance, checks
// sampled 1 time unit after each rising edge.
module tb_mem_store_capture;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [6:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        CLK, RST, CS, WE, rd_ready, win_ready, clr_ovf;
  logic [6:0]  Address;
  logic [31:0] Mem_Bus;
  logic        rd_valid, overflow;
  logic [6:0]  rd_addr;
  logic [31:0] rd_data;
  logic [4:0]  count;
  logic [7:0]  drop_cnt;
  logic        win_valid, win_ovf;
  logic [6:0]  win_addr;
  logic [31:0] win_data;
  logic [4:0]  win_count;
  logic [7:0]  win_drop;

  ent_t        sb[$];
  ent_t        wq[$];
  logic        exp_ovf;
  logic [7:0]  exp_drop;
  logic [31:0] last_pop;
  int          n_pass, n_total;

  mem_store_capture #(.DEPTH(DEPTH), .ADDR_W(7), .DATA_W(32), .WIN_LO(0), .WIN_HI(127)) dut (
    .CLK(CLK), .RST(RST), .CS(CS), .WE(WE), .Address(Address), .Mem_Bus(Mem_Bus),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  mem_store_capture #(.DEPTH(DEPTH), .ADDR_W(7), .DATA_W(32), .WIN_LO(4), .WIN_HI(8)) dut_win (
    .CLK(CLK), .RST(RST), .CS(CS), .WE(WE), .Address(Address), .Mem_Bus(Mem_Bus),
    .rd_valid(win_valid), .rd_ready(win_ready), .rd_addr(win_addr), .rd_data(win_data),
    .count(win_count), .overflow(win_ovf), .drop_cnt(win_drop), .clr_ovf(clr_ovf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One bus cycle on both instances: check current state against the model,
  // then drive inputs and advance the model by what the coming edge should do.
  task automatic cyc(input bit cs, input bit we, input logic [6:0] a, input logic [31:0] d,
                     input bit rdy, input bit clr);
    ent_t e;
    bit   pop_m, drop_m;
    chk("valid", 64'(rd_valid), 64'(sb.size() != 0));
    chk("count", 64'(count), 64'(sb.size()));
    chk("overflow", 64'(overflow), 64'(exp_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    pop_m  = rdy && (sb.size() != 0);
    drop_m = 1'b0;
    if (pop_m) begin
      e = sb.pop_front();
      chk("head_addr", 64'(rd_addr), 64'(e.a));
      chk("head_data", 64'(rd_data), 64'(e.d));
      last_pop = e.d;
    end
    if (cs && we) begin
      if (sb.size() < DEPTH) sb.push_back('{a: a, d: d});
      else drop_m = 1'b1;
      if (a >= 7'd4 && a <= 7'd8 && wq.size() < DEPTH) wq.push_back('{a: a, d: d});
    end
    if (clr) begin
      exp_ovf  = 1'b0;
      exp_drop = 8'd0;
    end else if (drop_m) begin
      exp_ovf = 1'b1;
      if (exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
    end
    CS = cs; WE = we; Address = a; Mem_Bus = d; rd_ready = rdy; clr_ovf = clr;
    tick();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input bit store_during);
    RST = 1'b1; CS = store_during; WE = store_during; Address = 7'd6;
    Mem_Bus = 32'hDEAD; rd_ready = 1'b0; win_ready = 1'b0; clr_ovf = 1'b0;
    tick();
    RST = 1'b0; CS = 1'b0; WE = 1'b0;
    sb.delete(); wq.delete();
    exp_ovf = 1'b0; exp_drop = 8'd0;
  endtask

  task automatic win_pop();
    ent_t e;
    chk("win_valid", 64'(win_valid), 64'(1));
    e = wq.pop_front();
    chk("win_addr", 64'(win_addr), 64'(e.a));
    chk("win_data", 64'(win_data), 64'(e.d));
    win_ready = 1'b1;
    idle();
    win_ready = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0; exp_ovf = 1'b0; exp_drop = 8'd0; last_pop = '0;
    RST = 1'b1; CS = 1'b0; WE = 1'b0; Address = '0; Mem_Bus = '0;
    rd_ready = 1'b0; win_ready = 1'b0; clr_ovf = 1'b0;
    tick(); tick();
    RST = 1'b0;
    chk("rst_valid", 64'(rd_valid), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    chk("rst_drop", 64'(drop_cnt), 64'(0));

    // Reads only: nothing may be captured.
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 7'(i), 32'hFFFF_0000 + 32'(i), 1'b0, 1'b0);

    // Single store, then a one-cycle pop.
    cyc(1'b1, 1'b1, 7'h05, 32'h12, 1'b0, 1'b0);
    chk("single_addr", 64'(rd_addr), 64'(5));
    chk("single_data", 64'(rd_data), 64'(32'h12));
    chk("single_count", 64'(count), 64'(1));
    cyc(1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0);
    chk("single_popped_valid", 64'(rd_valid), 64'(0));
    idle();

    // Window filter on the [4,8] instance.
    do_reset(1'b0);
    cyc(1'b1, 1'b1, 7'd3, 32'h303, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 7'd4, 32'h304, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 7'd8, 32'h308, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 7'd9, 32'h309, 1'b0, 1'b0);
    chk("win_count", 64'(win_count), 64'(2));
    win_pop();
    win_pop();
    chk("win_empty", 64'(win_valid), 64'(0));
    idle();

    // Fill past full, drain in order, then saturate the drop counter.
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 7'(i), 32'(i), 1'b0, 1'b0);
    chk("fill_count", 64'(count), 64'(16));
    chk("fill_ovf", 64'(overflow), 64'(1));
    chk("fill_drop", 64'(drop_cnt), 64'(4));
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0);
    chk("drain_last", 64'(last_pop), 64'(15));
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 7'(i + 40), 32'h500 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1, 7'd100, 32'h9000 + 32'(i), 1'b0, 1'b0);
    chk("sat_drop", 64'(drop_cnt), 64'(255));
    // Clear while a drop is happening: the clear wins.
    cyc(1'b1, 1'b1, 7'd101, 32'h77, 1'b0, 1'b1);
    chk("clr_ovf", 64'(overflow), 64'(0));
    chk("clr_drop", 64'(drop_cnt), 64'(0));

    // Push and pop together on a full queue.
    cyc(1'b1, 1'b1, 7'h10, 32'hAA, 1'b1, 1'b0);
    chk("fullpp_count", 64'(count), 64'(16));
    chk("fullpp_ovf", 64'(overflow), 64'(0));
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0);
    chk("fullpp_last", 64'(last_pop), 64'(32'hAA));
    chk("fullpp_empty", 64'(rd_valid), 64'(0));

    // Streaming across pointer wraps with a toggling consumer.
    for (int i = 0; i < 40; i++)
      cyc(1'b1, 1'b1, 7'(i), 32'h1000 + 32'(i), (i % 2) == 1, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0);
    chk("wrap_empty", 64'(rd_valid), 64'(0));

    // Mid-operation reset, with a store presented during the reset cycle.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 7'(i + 20), 32'h2000 + 32'(i), 1'b0, 1'b0);
    chk("pre_rst_count", 64'(count), 64'(5));
    do_reset(1'b1);
    chk("post_rst_count", 64'(count), 64'(0));
    chk("post_rst_valid", 64'(rd_valid), 64'(0));
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
